// File: rtl/ctrl_wb_bridge.sv
// Byte-command to Wishbone bridge: a header byte (we, adr) plus an optional data byte
// becomes one 8-bit Wishbone transfer; read results come back on the tx byte stream.
module ctrl_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [7:0]  TIMEOUT_DATA   = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       wb_we_o,
  output logic [3:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  output logic       wb_stb_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i,
  output logic       err_o
);

  typedef enum logic [1:0] {IDLE, DATA, BUS, RESP} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] wait_count;
  logic       unused_hdr_bits;

  assign unused_hdr_bits = ^rx_data_i[6:4];
  assign rx_ready_o = (state == IDLE) || (state == DATA);

  // In BUS, wb_we_o doubles as the read/write flag since it is stable for the whole transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      wait_count <= 8'd0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= 4'd0;
      wb_dat_o   <= 8'd0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= 8'd0;
      err_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid_i) begin
            wb_adr_o <= rx_data_i[3:0];
            if (rx_data_i[7]) begin
              state <= DATA;
            end else begin
              wb_we_o    <= 1'b0;
              wb_stb_o   <= 1'b1;
              wait_count <= 8'd0;
              state      <= BUS;
            end
          end
        end
        DATA: begin
          if (rx_valid_i) begin
            wb_dat_o   <= rx_data_i;
            wb_we_o    <= 1'b1;
            wb_stb_o   <= 1'b1;
            wait_count <= 8'd0;
            state      <= BUS;
          end
        end
        BUS: begin
          // An ack on the final allowed cycle still wins over the timeout.
          if (wb_ack_i) begin
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            if (wb_we_o) begin
              state <= IDLE;
            end else begin
              tx_data_o  <= wb_dat_i;
              tx_valid_o <= 1'b1;
              state      <= RESP;
            end
          end else if (wait_count == LAST_WAIT) begin
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            err_o    <= 1'b1;
            if (wb_we_o) begin
              state <= IDLE;
            end else begin
              tx_data_o  <= TIMEOUT_DATA;
              tx_valid_o <= 1'b1;
              state      <= RESP;
            end
          end else begin
            wait_count <= wait_count + 8'd1;
          end
        end
        RESP: begin
          if (tx_ready_i) begin
            tx_valid_o <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_wb_bridge.sv
// Directed bench for ctrl_wb_bridge: a vector table of single transactions plus
// hand-written sequences for timeout, backpressure, reset and back-to-back traffic.
module tb_ctrl_wb_bridge;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] rx_data_i = 8'd0;
  logic       rx_valid_i = 1'b0;
  logic       rx_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i = 1'b0;
  logic       wb_we_o;
  logic [3:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic       wb_stb_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;
  logic       err_o;

  typedef struct {
    logic       we;
    logic [3:0] adr;
    logic [7:0] dat;
  } bus_rec_t;

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] dat;
    int         wait_n;
    logic [7:0] rdata;
    logic       exp_we;
    logic [3:0] exp_adr;
    logic [7:0] exp_wdat;
    logic [7:0] exp_tx;
    int         exp_stb;
    logic       exp_err;
  } vec_t;

  bus_rec_t   bus_log[$];
  vec_t       vecs[5];
  int         stb_cycles = 0;
  int         stb_run = 0;
  int         ack_wait = 0;
  logic       force_ack = 1'b0;
  logic [7:0] rdata = 8'd0;
  int         checks = 0;
  int         errors = 0;

  ctrl_wb_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Responder: acks combinationally once stb has been high for ack_wait earlier cycles.
  assign wb_dat_i = rdata;
  assign wb_ack_i = force_ack || (wb_stb_o && (ack_wait >= 0) && (stb_run == ack_wait));

  always @(posedge clk_i) begin
    stb_run <= wb_stb_o ? stb_run + 1 : 0;
    if (wb_stb_o) stb_cycles++;
    if (wb_stb_o && wb_ack_i) bus_log.push_back('{wb_we_o, wb_adr_o, wb_dat_o});
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    for (int i = 0; i < 100 && !rx_ready_o; i++) tick();
    checkOutput("rx_ready_wait", rx_ready_o, 1);
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic wait_stb_done();
    for (int i = 0; i < 300 && wb_stb_o; i++) tick();
    checkOutput("stb_done", wb_stb_o, 0);
  endtask

  task automatic check_reset_values();
    checkOutput("rst_rx_ready", rx_ready_o, 1);
    checkOutput("rst_stb", wb_stb_o, 0);
    checkOutput("rst_we", wb_we_o, 0);
    checkOutput("rst_adr", wb_adr_o, 0);
    checkOutput("rst_dat", wb_dat_o, 0);
    checkOutput("rst_tx_valid", tx_valid_o, 0);
    checkOutput("rst_tx_data", tx_data_o, 0);
    checkOutput("rst_err", err_o, 0);
  endtask

  // One full transaction; the response byte is drained right after it is checked.
  task automatic applyStimulus(input vec_t v);
    bus_log.delete();
    stb_cycles = 0;
    ack_wait   = v.wait_n;
    rdata      = v.rdata;
    send_byte(v.hdr);
    if (v.exp_we) send_byte(v.dat);
    wait_stb_done();
    checkOutput("stb_cycles", stb_cycles, v.exp_stb);
    checkOutput("bus_count", bus_log.size(), 1);
    if (bus_log.size() == 1) begin
      checkOutput("bus_we", bus_log[0].we, v.exp_we);
      checkOutput("bus_adr", bus_log[0].adr, v.exp_adr);
      if (v.exp_we) checkOutput("bus_dat", bus_log[0].dat, v.exp_wdat);
    end
    checkOutput("we_idle", wb_we_o, 0);
    checkOutput("err", err_o, v.exp_err);
    if (v.exp_we) begin
      checkOutput("wr_rx_ready", rx_ready_o, 1);
      checkOutput("wr_tx_valid", tx_valid_o, 0);
    end else begin
      checkOutput("rd_tx_valid", tx_valid_o, 1);
      checkOutput("rd_tx_data", tx_data_o, v.exp_tx);
      checkOutput("rd_rx_ready", rx_ready_o, 0);
      tx_ready_i = 1'b1;
      tick();
      tx_ready_i = 1'b0;
      checkOutput("rd_tx_drop", tx_valid_o, 0);
      checkOutput("rd_idle", rx_ready_o, 1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b2b_bytes[6];
    vec_t       v;

    vecs[0] = '{8'h82, 8'h5A, 0,  8'h00, 1'b1, 4'h2, 8'h5A, 8'h00, 1,  1'b0};
    vecs[1] = '{8'h01, 8'h00, 3,  8'hC3, 1'b0, 4'h1, 8'h00, 8'hC3, 4,  1'b0};
    vecs[2] = '{8'h75, 8'h00, 0,  8'hA5, 1'b0, 4'h5, 8'h00, 8'hA5, 1,  1'b0};
    vecs[3] = '{8'hFF, 8'hE7, 2,  8'h00, 1'b1, 4'hF, 8'hE7, 8'h00, 3,  1'b0};
    vecs[4] = '{8'h0E, 8'h00, 15, 8'h7E, 1'b0, 4'hE, 8'h00, 8'h7E, 16, 1'b0};

    #1 rst_i = 1'b1;
    #1 check_reset_values();
    tick();
    tick();
    rst_i = 1'b0;
    tick();

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Acks outside a transfer must be ignored.
    force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stray_ack_ready", rx_ready_o, 1);
      checkOutput("stray_ack_tx", tx_valid_o, 0);
    end
    force_ack = 1'b0;

    // Read timeout, then a successful write with err still set.
    bus_log.delete();
    stb_cycles = 0;
    ack_wait   = -1;
    send_byte(8'h07);
    wait_stb_done();
    checkOutput("to_stb_cycles", stb_cycles, 16);
    checkOutput("to_bus_count", bus_log.size(), 0);
    checkOutput("to_tx_valid", tx_valid_o, 1);
    checkOutput("to_tx_data", tx_data_o, 8'hFF);
    checkOutput("to_err", err_o, 1);
    tx_ready_i = 1'b1;
    tick();
    tx_ready_i = 1'b0;
    v = '{8'h83, 8'h44, 0, 8'h00, 1'b1, 4'h3, 8'h44, 8'h00, 1, 1'b1};
    applyStimulus(v);

    // Backpressure on the response byte.
    ack_wait = 0;
    rdata    = 8'h3C;
    send_byte(8'h02);
    wait_stb_done();
    rdata = 8'h99;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_tx_valid", tx_valid_o, 1);
      checkOutput("bp_tx_data", tx_data_o, 8'h3C);
      checkOutput("bp_rx_ready", rx_ready_o, 0);
      tick();
    end
    tx_ready_i = 1'b1;
    tick();
    tx_ready_i = 1'b0;
    checkOutput("bp_tx_drop", tx_valid_o, 0);
    checkOutput("bp_rx_ready_after", rx_ready_o, 1);

    // Reset while waiting for write data; the next byte must be a fresh header.
    send_byte(8'h80);
    #2 rst_i = 1'b1;
    #1 check_reset_values();
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    v = '{8'h00, 8'h00, 0, 8'h11, 1'b0, 4'h0, 8'h00, 8'h11, 1, 1'b0};
    applyStimulus(v);

    // Back-to-back writes with rx_valid held high throughout.
    b2b_bytes = '{8'h80, 8'h10, 8'h81, 8'h20, 8'h82, 8'h30};
    bus_log.delete();
    stb_cycles = 0;
    ack_wait   = 0;
    rx_valid_i = 1'b1;
    foreach (b2b_bytes[i]) begin
      rx_data_i = b2b_bytes[i];
      for (int j = 0; j < 100 && !rx_ready_o; j++) tick();
      tick();
    end
    rx_valid_i = 1'b0;
    wait_stb_done();
    checkOutput("b2b_stb_cycles", stb_cycles, 3);
    checkOutput("b2b_count", bus_log.size(), 3);
    if (bus_log.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput("b2b_we", bus_log[i].we, 1);
        checkOutput("b2b_adr", bus_log[i].adr, i);
        checkOutput("b2b_dat", bus_log[i].dat, (i + 1) * 16);
      end
    end
    checkOutput("b2b_err", err_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
